dds_strobe_checker: RTL and testbench

Receive-side monitor for the fractional-rate enable strobe produced by the team's DDS rate generator (phase step ADD_NUM per clock, modulus MAX_NUM).
- Any MAX_NUM consecutive cycles of a correct strobe stream contain exactly ADD_NUM strobes.
- Adjacent strobes are floor(MAX/ADD) or ceil(MAX/ADD) cycles apart.
- The block checks both properties, acquires lock and counts errors.
- It sits next to any consumer of a DDS enable, as a self-check and status source.

---
 rtl/dds_pkg.sv | 23 ++
 rtl/dds_window_counter.sv | 49 ++++
 rtl/dds_strobe_checker.sv | 114 +++++++++++
 tb/tb_dds_strobe_checker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS strobe checker: FSM states and the
// legal strobe-spacing bounds derived from the phase step and modulus.
package dds_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } dds_state_t;

    // Shortest legal distance between adjacent strobes: floor(MAX/ADD).
    function automatic int unsigned gap_min(input int unsigned add_num,
                                            input int unsigned max_num);
        return max_num / add_num;
    endfunction

    // Longest legal distance between adjacent strobes: ceil(MAX/ADD).
    function automatic int unsigned gap_max(input int unsigned add_num,
                                            input int unsigned max_num);
        return (max_num + add_num - 1) / add_num;
    endfunction

endpackage

// File: rtl/dds_window_counter.sv
// MAX_NUM-cycle window aligned to the acquisition strobe; tallies strobes
// and flags the closing cycle together with the count compare.
module dds_window_counter #(
    parameter int unsigned             COUNT_WIDTH = 4,
    parameter logic [COUNT_WIDTH-1:0]  ADD_NUM     = COUNT_WIDTH'(3),
    parameter logic [COUNT_WIDTH-1:0]  MAX_NUM     = COUNT_WIDTH'(5)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   active,
    input  logic                   clear,
    input  logic                   strobe,
    output logic                   win_end,
    output logic                   win_err,
    output logic [COUNT_WIDTH-1:0] win_tally
);

    localparam logic [COUNT_WIDTH-1:0] LAST = MAX_NUM - 1'b1;

    logic [COUNT_WIDTH-1:0] cyc;
    logic [COUNT_WIDTH-1:0] cnt;

    // Tally includes the strobe of the current cycle, so the closing cycle counts.
    always_comb begin
        win_tally = cnt + {{(COUNT_WIDTH-1){1'b0}}, strobe};
        win_end   = active && (cyc == LAST);
        win_err   = win_end && (win_tally != ADD_NUM);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cyc <= '0;
            cnt <= '0;
        end else if (start) begin
            cyc <= COUNT_WIDTH'(1);
            cnt <= COUNT_WIDTH'(1);
        end else if (active) begin
            if (win_end) begin
                cyc <= '0;
                cnt <= '0;
            end else begin
                cyc <= cyc + 1'b1;
                cnt <= win_tally;
            end
        end
    end

endmodule

// File: rtl/dds_strobe_checker.sv
// Receive-side monitor for a DDS fractional-rate enable: checks strobe
// spacing and per-window strobe count, acquires lock and counts violations.
module dds_strobe_checker
    import dds_pkg::*;
#(
    parameter int unsigned             COUNT_WIDTH  = 4,
    parameter logic [COUNT_WIDTH-1:0]  ADD_NUM      = COUNT_WIDTH'(3),
    parameter logic [COUNT_WIDTH-1:0]  MAX_NUM      = COUNT_WIDTH'(5),
    parameter int unsigned             LOCK_WINDOWS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   strobe_in,
    output logic                   locked,
    output logic                   err_pulse,
    output logic [7:0]             err_count,
    output logic [COUNT_WIDTH-1:0] gap_last,
    output logic [COUNT_WIDTH-1:0] win_count
);

    localparam logic [COUNT_WIDTH-1:0] GAP_MIN =
        COUNT_WIDTH'(gap_min(32'(ADD_NUM), 32'(MAX_NUM)));
    localparam logic [COUNT_WIDTH-1:0] GAP_MAX =
        COUNT_WIDTH'(gap_max(32'(ADD_NUM), 32'(MAX_NUM)));
    localparam logic [COUNT_WIDTH-1:0] GAP_LIMIT = GAP_MAX + 1'b1;
    localparam int unsigned            CLEAN_W   = $clog2(LOCK_WINDOWS + 1);
    localparam logic [CLEAN_W-1:0]     LOCK_LIM  = CLEAN_W'(LOCK_WINDOWS);

    dds_state_t             state;
    dds_state_t             state_nx;
    logic [COUNT_WIDTH-1:0] gap;
    logic [CLEAN_W-1:0]     clean;
    logic                   active;
    logic                   start;
    logic                   gap_err;
    logic                   err;
    logic                   clean_win;
    logic                   win_end;
    logic                   win_err;
    logic [COUNT_WIDTH-1:0] win_tally;

    dds_window_counter #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .ADD_NUM     (ADD_NUM),
        .MAX_NUM     (MAX_NUM)
    ) u_window (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .active    (active),
        .clear     (err),
        .strobe    (strobe_in),
        .win_end   (win_end),
        .win_err   (win_err),
        .win_tally (win_tally)
    );

    // gap saturates at GAP_LIMIT, so reaching it doubles as the no-strobe timeout.
    always_comb begin
        active    = (state != IDLE);
        start     = (state == IDLE) && strobe_in;
        gap_err   = active && ((gap == GAP_LIMIT) ||
                    (strobe_in && ((gap < GAP_MIN) || (gap > GAP_MAX))));
        err       = gap_err || win_err;
        clean_win = win_end && !err;
        state_nx  = state;
        case (state)
            IDLE: if (strobe_in) state_nx = ACQ;
            ACQ: begin
                if (err)
                    state_nx = IDLE;
                else if (clean_win && ((clean + 1'b1) >= LOCK_LIM))
                    state_nx = LOCK;
            end
            LOCK: if (err) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gap       <= '0;
            clean     <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            gap_last  <= '0;
            win_count <= '0;
        end else begin
            state     <= state_nx;
            locked    <= (state_nx == LOCK);
            err_pulse <= err;

            if (strobe_in)
                gap <= COUNT_WIDTH'(1);
            else if (gap != GAP_LIMIT)
                gap <= gap + 1'b1;

            if (err || (state == IDLE))
                clean <= '0;
            else if (clean_win && (clean != LOCK_LIM))
                clean <= clean + 1'b1;

            if (err && (err_count != 8'hFF))
                err_count <= err_count + 1'b1;
            if (active && strobe_in)
                gap_last <= gap;
            if (win_end)
                win_count <= win_tally;
        end
    end

endmodule

// File: tb/tb_dds_strobe_checker.sv
// Bench for dds_strobe_checker: default instance (3/5) and a 5/5 instance,
// directed table and sequences plus randomized DDS streams against a model.
module tb_dds_strobe_checker;

    localparam int LOCK_W = 4;

    logic       clk = 1'b0;
    logic       rst0, s0, rst1, s1;
    logic       locked0, pulse0, locked1, pulse1;
    logic [7:0] cnt0, cnt1;
    logic [3:0] gl0, win0, gl1, win1;

    int errors = 0;
    int checks = 0;
    int n = 0;

    always #5 clk = ~clk;

    dds_strobe_checker dut (
        .clk(clk), .rst(rst0), .strobe_in(s0), .locked(locked0),
        .err_pulse(pulse0), .err_count(cnt0), .gap_last(gl0), .win_count(win0)
    );

    dds_strobe_checker #(
        .COUNT_WIDTH(4), .ADD_NUM(4'd5), .MAX_NUM(4'd5), .LOCK_WINDOWS(4)
    ) dut5 (
        .clk(clk), .rst(rst1), .strobe_in(s1), .locked(locked1),
        .err_pulse(pulse1), .err_count(cnt1), .gap_last(gl1), .win_count(win1)
    );

    // Reference model: works on absolute strobe times, not on counters.
    int m_add [2] = '{3, 5};
    int m_max [2] = '{5, 5};
    bit m_act [2];
    int m_acq [2];
    int m_last [2];
    int m_clean [2];
    int m_st [2][$];
    int e_lock [2], e_pulse [2], e_cnt [2], e_gl [2], e_win [2];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, n);
        end
    endtask

    task automatic model_step(input int id, input bit r, input bit s, input int t);
        int g, c, gmin, gmax;
        bit err;
        gmin = m_max[id] / m_add[id];
        gmax = (m_max[id] + m_add[id] - 1) / m_add[id];
        if (r) begin
            m_act[id] = 0; e_lock[id] = 0; e_pulse[id] = 0;
            e_cnt[id] = 0; e_gl[id] = 0; e_win[id] = 0;
            return;
        end
        e_pulse[id] = 0;
        if (!m_act[id]) begin
            if (s) begin
                m_act[id] = 1; m_acq[id] = t; m_last[id] = t; m_clean[id] = 0;
                m_st[id].delete();
                m_st[id].push_back(t);
            end
            return;
        end
        err = 0;
        g = t - m_last[id];
        if (s) begin
            e_gl[id] = g;
            if (g < gmin || g > gmax) err = 1;
            m_st[id].push_back(t);
            m_last[id] = t;
        end
        if (g > gmax) err = 1;
        while (m_st[id].size() > 0 && m_st[id][0] < t - m_max[id] + 1)
            void'(m_st[id].pop_front());
        if ((t - m_acq[id]) % m_max[id] == m_max[id] - 1) begin
            c = m_st[id].size();
            e_win[id] = c;
            if (c != m_add[id]) err = 1;
            else if (!err) m_clean[id]++;
        end
        e_pulse[id] = int'(err);
        if (err) begin
            m_act[id] = 0;
            e_lock[id] = 0;
            if (e_cnt[id] < 255) e_cnt[id]++;
        end else begin
            e_lock[id] = (m_clean[id] >= LOCK_W) ? 1 : 0;
        end
    endtask

    task automatic compare(input int id);
        string p;
        p = (id == 0) ? "d35" : "d55";
        chk({p, " locked"},    (id == 0) ? int'(locked0) : int'(locked1), e_lock[id]);
        chk({p, " err_pulse"}, (id == 0) ? int'(pulse0)  : int'(pulse1),  e_pulse[id]);
        chk({p, " err_count"}, (id == 0) ? int'(cnt0)    : int'(cnt1),    e_cnt[id]);
        chk({p, " gap_last"},  (id == 0) ? int'(gl0)     : int'(gl1),     e_gl[id]);
        chk({p, " win_count"}, (id == 0) ? int'(win0)    : int'(win1),    e_win[id]);
    endtask

    task automatic step(input bit r0, input bit v0, input bit r1, input bit v1);
        rst0 = r0; s0 = v0; rst1 = r1; s1 = v1;
        @(posedge clk);
        #1;
        model_step(0, r0, v0, n);
        model_step(1, r1, v1, n);
        compare(0);
        compare(1);
        n++;
    endtask

    // Ideal 3-of-5 stream with its first strobe at k=1.
    function automatic bit pat(input int k);
        int p;
        if (k < 1) return 1'b0;
        p = (k - 1) % 5;
        return (p == 0 || p == 2 || p == 3);
    endfunction

    typedef struct {
        bit s;
        int lk;
        int ep;
        int ec;
        int gl;
        int win;
    } vec_t;

    vec_t tbl [11];

    initial begin
        bit v0, v1, r0, r1;
        int acc0, acc1;

        tbl[0]  = '{1'b0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1'b1, 0, 0, 0, 0, 0};
        tbl[2]  = '{1'b0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1'b1, 0, 0, 0, 2, 0};
        tbl[4]  = '{1'b1, 0, 0, 0, 1, 0};
        tbl[5]  = '{1'b0, 0, 0, 0, 1, 3};
        tbl[6]  = '{1'b1, 0, 0, 0, 2, 3};
        tbl[7]  = '{1'b0, 0, 0, 0, 2, 3};
        tbl[8]  = '{1'b1, 0, 0, 0, 2, 3};
        tbl[9]  = '{1'b1, 0, 0, 0, 1, 3};
        tbl[10] = '{1'b0, 0, 0, 0, 1, 3};

        rst0 = 1'b1; s0 = 1'b0; rst1 = 1'b1; s1 = 1'b0;
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        chk("reset locked", int'(locked0), 0);
        chk("reset err_count", int'(cnt0), 0);
        chk("reset win_count", int'(win0), 0);

        for (int k = 0; k < 11; k++) begin
            step(0, tbl[k].s, 0, 1'b1);
            chk("tbl locked",    int'(locked0), tbl[k].lk);
            chk("tbl err_pulse", int'(pulse0),  tbl[k].ep);
            chk("tbl err_count", int'(cnt0),    tbl[k].ec);
            chk("tbl gap_last",  int'(gl0),     tbl[k].gl);
            chk("tbl win_count", int'(win0),    tbl[k].win);
        end

        // Ideal lock, dropped strobe, extra strobe, relock, then reset while locked.
        for (int k = 11; k <= 120; k++) begin
            v0 = pat(k);
            if (k == 33) v0 = 1'b0;
            if (k == 62) v0 = 1'b1;
            v1 = (k != 30);
            step(k == 90, v0, 0, v1);
            if (k == 18) chk("d55 pre-lock", int'(locked1), 0);
            if (k == 19) begin
                chk("d35 pre-lock", int'(locked0), 0);
                chk("d55 lock at 20", int'(locked1), 1);
            end
            if (k == 20) chk("d35 lock at t+20", int'(locked0), 1);
            if (k == 30) chk("d55 still locked", int'(locked1), 1);
            if (k == 31) begin
                chk("d55 zero-cycle pulse", int'(pulse1), 1);
                chk("d55 zero-cycle count", int'(cnt1), 1);
                chk("d55 zero-cycle unlock", int'(locked1), 0);
            end
            if (k == 33) chk("drop no pulse yet", int'(pulse0), 0);
            if (k == 34) begin
                chk("drop timeout pulse", int'(pulse0), 1);
                chk("drop unlock", int'(locked0), 0);
                chk("drop err_count", int'(cnt0), 1);
            end
            if (k == 35) chk("drop pulse one cycle", int'(pulse0), 0);
            if (k == 51) chk("d55 relock", int'(locked1), 1);
            if (k == 54) chk("drop relock early", int'(locked0), 0);
            if (k == 55) chk("drop relock", int'(locked0), 1);
            if (k == 64) chk("extra locked before end", int'(locked0), 1);
            if (k == 65) begin
                chk("extra pulse", int'(pulse0), 1);
                chk("extra win_count", int'(win0), 4);
                chk("extra err_count", int'(cnt0), 2);
                chk("extra unlock", int'(locked0), 0);
            end
            if (k == 89) chk("locked before rst", int'(locked0), 1);
            if (k == 90) begin
                chk("rst locked", int'(locked0), 0);
                chk("rst err_count", int'(cnt0), 0);
                chk("rst gap_last", int'(gl0), 0);
                chk("rst win_count", int'(win0), 0);
            end
            if (k == 110) chk("relock after rst", int'(locked0), 1);
        end

        // Continuous strobe at 3/5: one window error per window until saturation.
        for (int k = 0; k < 1400; k++) step(0, 1'b1, 0, 1'b1);
        chk("saturate err_count", int'(cnt0), 255);
        chk("d55 continuous clean", int'(cnt1), 1);
        for (int k = 0; k < 10; k++) step(0, 1'b1, 0, 1'b1);
        chk("saturate hold", int'(cnt0), 255);

        // Randomized DDS streams with occasional corruption, phase jumps and resets.
        step(1, 0, 1, 0);
        acc0 = $urandom_range(0, 4);
        acc1 = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) acc0 = $urandom_range(0, 4);
            acc0 += 3;
            v0 = (acc0 >= 5);
            if (v0) acc0 -= 5;
            acc1 += 5;
            v1 = (acc1 >= 5);
            if (v1) acc1 -= 5;
            if ($urandom_range(0, 63) == 0) v0 = ~v0;
            if ($urandom_range(0, 63) == 0) v1 = ~v1;
            r0 = ($urandom_range(0, 399) == 0);
            r1 = ($urandom_range(0, 399) == 0);
            step(r0, v0, r1, v1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
